// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the mem_resp latency-controlled memory responder.
package mem_resp_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        RD,
        WR,
        BAD
    } op_t;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port 16-bit word storage: synchronous write, combinational read, no reset.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [15:0]   i_wdata,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_resp.sv
// Memory responder: accepts one request in IDLE, waits LATENCY cycles, then pulses done.
//   state | meaning
//   IDLE  | waiting for rd/wr; request is latched on acceptance
//   BUSY  | counting down latency; access happens when the counter reaches 0
//   DONE  | one-cycle completion pulse carrying data_out / err
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int AW      = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err
);

    state_t           r_state;
    op_t              r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [AW-1:0]    r_word;
    logic [15:0]      r_data;
    logic [15:0]      r_data_out;
    logic             r_err;

    logic        w_req;
    logic        w_bad;
    logic        w_access;
    logic        w_we;
    logic [15:0] w_rdata;
    logic        w_unused_addr;

    assign w_req    = rd | wr;
    assign w_bad    = (rd & wr) | addr[0];
    assign w_access = (r_state == BUSY) && (r_cnt == '0);
    // Reset in the access cycle must still suppress the write.
    assign w_we     = w_access && (r_op == WR) && !rst;

    // Upper address bits intentionally alias onto the word index.
    assign w_unused_addr = ^addr;

    mem_resp_array #(
        .AW (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_word),
        .i_wdata (r_data),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_op       <= RD;
            r_cnt      <= '0;
            r_word     <= '0;
            r_data     <= '0;
            r_data_out <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_data_out <= '0;
                    r_err      <= 1'b0;
                    if (w_req) begin
                        r_word <= addr[AW:1];
                        r_data <= data_in;
                        if (w_bad) begin
                            r_op    <= BAD;
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_op    <= rd ? RD : WR;
                            r_cnt   <= CNT_W'(LATENCY - 1);
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == '0) begin
                        if (r_op == RD) begin
                            r_data_out <= w_rdata;
                        end
                        r_state <= DONE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
                    r_data_out <= '0;
                    r_err      <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign data_out = r_data_out;
    assign done     = (r_state == DONE);
    assign err      = r_err;
    assign stall    = ((r_state == IDLE) && w_req) || (r_state == BUSY);

endmodule
